// File: rtl/stack_unit_pkg.sv
// Shared opcode, write-back select and sizing constants for the stack unit and its decoder.
// Also defines the pointer-state encoding derived from the stack pointer.
package stack_unit_pkg;

  localparam logic [3:0] OP_PUSH    = 4'b1110;
  localparam logic [3:0] OP_POP     = 4'b1111;
  localparam logic [1:0] WD_POP     = 2'b10;
  localparam int         DATA_W_DEF = 16;
  localparam int         DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    PS_EMPTY   = 2'd0,
    PS_PARTIAL = 2'd1,
    PS_FULL    = 2'd2
  } ptr_state_e;

  typedef struct packed {
    logic push;
    logic pop;
  } stack_op_t;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read is combinational; no backpressure.
module stack_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack for PUSH/POP with sticky overflow/underflow flags; top-of-stack readable with zero latency.
// Updates on the rising edge only while en=1; en=0 stalls with no state change, there is no backpressure.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] pop_data,
  output logic [PTR_W-1:0]  sp,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int               AW     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] SP_MAX = PTR_W'(DEPTH);

  logic [PTR_W-1:0]  sp_q, sp_d;
  logic              ovf_q, unf_q, ovf_set, unf_set;
  logic              we;
  logic [AW-1:0]     waddr, top_idx;
  logic [DATA_W-1:0] rd_dat;
  ptr_state_e        pst;
  stack_op_t         op;

  assign op      = '{push: push, pop: pop};
  assign top_idx = sp_q[AW-1:0] - AW'(1);

  always_comb begin
    pst = PS_PARTIAL;
    if (sp_q == '0)         pst = PS_EMPTY;
    else if (sp_q == SP_MAX) pst = PS_FULL;
  end

  always_comb begin
    sp_d    = sp_q;
    we      = 1'b0;
    waddr   = sp_q[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case ({op.push, op.pop})
      2'b10: begin
        if (pst == PS_FULL) begin
          ovf_set = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + PTR_W'(1);
        end
      end
      2'b01: begin
        if (pst == PS_EMPTY) unf_set = 1'b1;
        else                 sp_d    = sp_q - PTR_W'(1);
      end
      2'b11: begin
        // Simultaneous push+pop replaces the top; on an empty stack it degrades to a push.
        we = 1'b1;
        if (pst == PS_EMPTY) sp_d  = sp_q + PTR_W'(1);
        else                 waddr = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (en) begin
      sp_q  <= sp_d;
      ovf_q <= ovf_set | (ovf_q & ~clr_err);
      unf_q <= unf_set | (unf_q & ~clr_err);
    end
  end

  // Storage is not reset, so a write pending while rst_n is low must be suppressed here.
  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we & en & rst_n),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (top_idx),
    .rdata (rd_dat)
  );

  assign pop_data = (pst == PS_EMPTY) ? '0 : rd_dat;
  assign sp       = sp_q;
  assign empty    = (pst == PS_EMPTY);
  assign full     = (pst == PS_FULL);
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with hand-computed expectations.
module tb_stack_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        push;
  logic        pop;
  logic [15:0] push_data;
  logic        clr_err;
  logic [15:0] pop_data;
  logic [4:0]  sp;
  logic        empty, full, ovf, unf;

  int total = 0;
  int bad   = 0;

  stack_unit #(.DATA_W(16), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .clr_err   (clr_err),
    .pop_data  (pop_data),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic pu, input logic po,
                       input logic [15:0] d, input logic c);
    en = e; push = pu; pop = po; push_data = d; clr_err = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic e, input logic pu, input logic po,
                      input logic [15:0] d, input logic c);
    drive(e, pu, po, d, c);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_flags", 32'({ovf, unf}), 0);
    chk("rst_pop_data", 32'(pop_data), 0);
    #20;
    rst_n = 1'b1;
    tick();

    // 1: asynchronous reset mid-stream after three pushes, with a push pending
    step(1'b1, 1'b1, 1'b0, 16'hA001, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'hA002, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'hA003, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'hA004, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'hA005, 1'b0);
    chk("t1_sp_before", 32'(sp), 3);
    chk("t1_unf_before", 32'(unf), 1);
    drive(1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t1_sp", 32'(sp), 0);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_flags", 32'({ovf, unf}), 0);
    chk("t1_pop_data", 32'(pop_data), 0);
    tick();
    chk("t1_sp_held", 32'(sp), 0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 2: push three, pop three
    step(1'b1, 1'b1, 1'b0, 16'h1111, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h2222, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h3333, 1'b0);
    chk("t2_sp3", 32'(sp), 3);
    drive(1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
    chk("t2_pop0", 32'(pop_data), 32'h3333);
    tick();
    chk("t2_sp2", 32'(sp), 2);
    chk("t2_pop1", 32'(pop_data), 32'h2222);
    tick();
    chk("t2_sp1", 32'(sp), 1);
    chk("t2_pop2", 32'(pop_data), 32'h1111);
    tick();
    chk("t2_sp0", 32'(sp), 0);
    chk("t2_empty", 32'(empty), 1);

    // 3: fill, overflow, clear, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'(i), 1'b0);
    chk("t3_full", 32'(full), 1);
    chk("t3_sp16", 32'(sp), 16);
    chk("t3_ovf_clean", 32'(ovf), 0);
    step(1'b1, 1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk("t3_sp_sat", 32'(sp), 16);
    chk("t3_ovf", 32'(ovf), 1);
    chk("t3_top", 32'(pop_data), 15);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("t3_ovf_clr", 32'(ovf), 0);
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
      chk($sformatf("t3_drain%0d", i), 32'(pop_data), 32'(i));
      tick();
    end
    chk("t3_empty", 32'(empty), 1);

    // 4: underflow, clear, clear racing a fresh underflow
    step(1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
    chk("t4_unf", 32'(unf), 1);
    chk("t4_sp", 32'(sp), 0);
    chk("t4_pop_data", 32'(pop_data), 0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("t4_unf_clr", 32'(unf), 0);
    step(1'b1, 1'b0, 1'b1, 16'h0, 1'b1);
    chk("t4_unf_wins", 32'(unf), 1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

    // 5: simultaneous push+pop replaces top; from empty it is a push
    step(1'b1, 1'b1, 1'b0, 16'h1234, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0);
    chk("t5_top_before", 32'(pop_data), 32'hAAAA);
    step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0);
    chk("t5_sp", 32'(sp), 2);
    chk("t5_top", 32'(pop_data), 32'h5555);
    chk("t5_flags", 32'({ovf, unf}), 0);
    step(1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
    chk("t5_below", 32'(pop_data), 32'h1234);
    step(1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
    chk("t5_empty", 32'(empty), 1);
    step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0);
    chk("t5e_sp", 32'(sp), 1);
    chk("t5e_top", 32'(pop_data), 32'h5555);
    chk("t5e_flags", 32'({ovf, unf}), 0);
    step(1'b1, 1'b0, 1'b1, 16'h0, 1'b0);

    // 6: stall holds state, one enabled cycle gives exactly one push
    step(1'b1, 1'b1, 1'b0, 16'h7777, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h9999, 1'b1);
    chk("t6_sp_stall", 32'(sp), 1);
    chk("t6_top_stall", 32'(pop_data), 32'h7777);
    step(1'b1, 1'b1, 1'b0, 16'h9999, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t6_sp_one", 32'(sp), 2);
    chk("t6_top_one", 32'(pop_data), 32'h9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
